// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: MOSI frames -> command words, RAM read data -> MISO.
// Ports: clk, rst_n, ss_n, mosi, miso, rx_data/rx_valid, tx_data/tx_valid, cmd_err.
// Optional: define SPI_CMD_CHECK_EN to check cmd bits against the frame type.
module spi_slave_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              cmd_err
);

  localparam int WW = DATA_W + 2;
  localparam int CW = $clog2(WW + 1);
  localparam int TW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WW-2:0]   shift;
  logic            word_done;
  logic            tx_done;
  logic [TW-1:0]   tx_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic            rd_addr_done;

  logic [WW-1:0] word;
  logic          in_word;
  logic          cmd_ok;

  assign word    = {shift, mosi};
  assign in_word = (state == WRITE) || (state == READ_ADD)
                || (state == READ_DATA);

`ifdef SPI_CMD_CHECK_EN
  always_comb begin
    cmd_ok = 1'b0;
    case (state)
      WRITE:     cmd_ok = ~word[WW-1];
      READ_ADD:  cmd_ok = (word[WW-1:WW-2] == 2'b10);
      READ_DATA: cmd_ok = (word[WW-1:WW-2] == 2'b11);
      default:   cmd_ok = 1'b0;
    endcase
  end
`else
  assign cmd_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      shift        <= '0;
      word_done    <= 1'b0;
      tx_done      <= 1'b0;
      tx_cnt       <= '0;
      tx_sh        <= '0;
      rd_addr_done <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      cmd_err  <= 1'b0;

      if (in_word && !word_done) begin
        shift <= word[WW-2:0];
        if (cnt == CW'(WW - 1)) begin
          word_done <= 1'b1;
          cnt       <= '0;
          if (cmd_ok) begin
            rx_data  <= word;
            rx_valid <= 1'b1;
            if (state == READ_ADD)
              rd_addr_done <= 1'b1;
          end else begin
            cmd_err <= 1'b1;
            // a rejected read-data word never serialises
            tx_done <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      // rx_valid high means this is the word-completion cycle,
      // where tx_valid is not yet trusted
      if (state == READ_DATA && word_done && !rx_valid
          && !tx_done && tx_valid) begin
        miso         <= tx_data[DATA_W-1];
        tx_sh        <= {tx_data[DATA_W-2:0], 1'b0};
        tx_cnt       <= TW'(DATA_W - 1);
        tx_done      <= 1'b1;
        rd_addr_done <= 1'b0;
      end else if (tx_cnt != '0) begin
        miso   <= tx_sh[DATA_W-1];
        tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
        tx_cnt <= tx_cnt - TW'(1);
      end else begin
        miso <= 1'b0;
      end

      if (ss_n) begin
        state     <= IDLE;
        cnt       <= '0;
        word_done <= 1'b0;
        tx_done   <= 1'b0;
        tx_cnt    <= '0;
        miso      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= CHK_CMD;
            cnt       <= '0;
            word_done <= 1'b0;
            tx_done   <= 1'b0;
          end
          CHK_CMD: begin
            unique case (1'b1)
              !mosi:                 state <= WRITE;
              mosi && !rd_addr_done: state <= READ_ADD;
              mosi && rd_addr_done:  state <= READ_DATA;
            endcase
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI slave front end that drives the single-port command RAM. Deserialises MOSI frames into 10-bit command words (rx_data, rx_valid) for the RAM, and serialises the RAM's 8-bit read data (tx_data, tx_valid) back out on MISO. Sits between the SPI pads and the RAM in the SPI slave wrapper. SPI timing is sampled on the system clock clk.

Parameters:
DATA_W, 8, RAM data width; command word width is DATA_W+2.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
ss_n  input  1  slave select, active low; high ends or aborts the frame
mosi  input  1  serial data in, sampled on each rising clk edge
miso  output  1  serial data out, registered
rx_data  output  DATA_W+2  command word to RAM, {cmd[1:0], payload[DATA_W-1:0]}
rx_valid  output  1  one-cycle pulse; rx_data valid
tx_data  input  DATA_W  read data from RAM
tx_valid  input  1  RAM read-data valid (level; may stay high)
cmd_err  output  1  one-cycle pulse on command mismatch (see Optional Feature)

Behaviour:
- Reset: state=IDLE, miso=0, rx_data=0, rx_valid=0, cmd_err=0, bit counter=0, rd_addr_done=0.
- Frame: ss_n falls; 1 selector bit; 10 word bits MSB first; for read-data frames, DATA_W readback bits on miso.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: ss_n=0 -> CHK_CMD; otherwise stay.
- CHK_CMD: samples the selector bit, which is not part of the word. mosi=0 -> WRITE. mosi=1 and rd_addr_done=0 -> READ_ADD. mosi=1 and rd_addr_done=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift mosi into the word register for 10 consecutive edges (counter 0..9).
  - On the edge sampling bit 10: rx_data <= {shift[8:0], mosi} and rx_valid=1 for exactly that following cycle.
  - Further mosi is ignored.
- READ_ADD: rd_addr_done <= 1 on the same edge as the rx_valid assertion.
- WRITE and READ_ADD: after the word, hold the state until ss_n=1.
- READ_DATA, after the word:
  - tx_valid is ignored in the rx_valid cycle. From the next cycle onward, the first cycle with tx_valid=1 captures tx_data.
  - On that capture edge: miso <= tx_data[DATA_W-1]. The next DATA_W-1 edges present the remaining bits, MSB to LSB. miso then returns to 0.
  - rd_addr_done clears on the capture edge.
- Any state, ss_n=1 -> IDLE on the next edge, with these effects:
  - counters cleared, miso=0;
  - a partial word gives no rx_valid;
  - rx_data holds its last value;
  - rd_addr_done is unchanged unless a capture already occurred.
- Boundary: ss_n rising on the same edge as bit 10 still completes the word (rx_valid asserts) and goes to IDLE.
- A second read-data frame without an intervening read-address frame cannot occur: the selector routes to READ_ADD.

Optional Feature:
Macro SPI_CMD_CHECK_EN.
- Defined: the completed word's cmd bits [9:8] are checked against the state. WRITE requires 00 or 01, READ_ADD requires 10, READ_DATA requires 11.
  - On mismatch: rx_valid is suppressed, cmd_err pulses for 1 cycle, rd_addr_done is not set, and READ_DATA does not await tx_valid.
- Undefined: no check; every completed word is forwarded; cmd_err is tied 0.

Test Plan:
- Reset mid-frame (rst_n low during READ_DATA shifting) -> all outputs 0, state IDLE, rd_addr_done 0.
- Write-address frame: selector 0, word 00_1010_0101 -> rx_valid 1 cycle with rx_data=0x0A5, miso stays 0.
- Write-data frame: selector 0, word 01_0011_1100 -> rx_data=0x13C. Then a read-address frame: selector 1, word 10_1010_0101 -> rx_data=0x2A5, rd_addr_done=1.
- Read-data frame: selector 1, word 11_0000_0000; RAM model returns tx_data=0x3C with tx_valid one cycle after rx_valid -> miso shows 0,0,1,1,1,1,0,0 on consecutive cycles, then 0; rd_addr_done=0.
- Abort: ss_n high after 6 word bits -> no rx_valid, IDLE next edge. A following full frame decodes correctly.
- SPI_CMD_CHECK_EN: WRITE selector with word 11_0000_0001 -> no rx_valid, cmd_err 1 cycle. Without the macro -> rx_valid with rx_data=0x301, cmd_err 0.
